// File: rtl/avm_read_arbiter.sv
// Round-robin arbiter sharing one 16-bit Avalon-MM read master among NREQ requesters.
// An in-order tag FIFO routes each readdatavalid beat back to the requester that issued it.
module avm_read_arbiter #(
  parameter int NREQ    = 2,
  parameter int MAXPEND = 8,
  parameter int AW      = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              s_read,
  input  logic [NREQ*AW-1:0]           s_address,
  input  logic [NREQ*2-1:0]            s_byteenable,
  output logic [NREQ-1:0]              s_waitrequest,
  output logic [15:0]                  s_readdata,
  output logic [NREQ-1:0]              s_readdatavalid,
  output logic                         avm_m0_read,
  output logic [AW-1:0]                avm_m0_address,
  output logic [1:0]                   avm_m0_byteenable,
  input  logic [15:0]                  avm_m0_readdata,
  input  logic                         avm_m0_readdatavalid,
  input  logic                         avm_m0_waitrequest,
  output logic [$clog2(MAXPEND+1)-1:0] pending,
  output logic                         orphan_err
);
  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(MAXPEND+1);
  localparam int FW = (MAXPEND > 1) ? $clog2(MAXPEND) : 1;

  logic [IW-1:0] rr_ptr, lock_idx, grant, cand, head;
  logic          lock, gnt_vld, full, accept, pop, found;
  logic [IW-1:0] tag_mem [MAXPEND];
  logic [FW-1:0] wr_ptr, rd_ptr;

  function automatic logic [FW-1:0] nxt(input logic [FW-1:0] p);
    return (p == FW'(MAXPEND-1)) ? '0 : p + FW'(1);
  endfunction

  // A locked grant holds the address stable across waitrequest; otherwise search from rr_ptr.
  always_comb begin
    grant = rr_ptr;
    found = 1'b0;
    cand  = '0;
    if (lock) begin
      grant = lock_idx;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        cand = IW'((int'(rr_ptr) + k) % NREQ);
        if (!found && s_read[cand]) begin
          grant = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign gnt_vld           = s_read[grant];
  assign full              = (pending == PW'(MAXPEND));
  assign avm_m0_read       = gnt_vld & ~full & ~reset;
  assign avm_m0_address    = gnt_vld ? s_address[int'(grant)*AW +: AW] : '0;
  assign avm_m0_byteenable = gnt_vld ? s_byteenable[int'(grant)*2 +: 2] : '0;
  assign accept            = avm_m0_read & ~avm_m0_waitrequest;
  assign head              = tag_mem[rd_ptr];
  assign pop               = avm_m0_readdatavalid & (pending != '0) & ~reset;
  assign s_readdata        = avm_m0_readdata;

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign s_waitrequest[i]   = ~(accept && (grant == IW'(i)));
    assign s_readdatavalid[i] = pop && (head == IW'(i));
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr] <= grant;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      lock       <= 1'b0;
      lock_idx   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pending    <= '0;
      orphan_err <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= (grant == IW'(NREQ-1)) ? '0 : grant + IW'(1);
        lock   <= 1'b0;
        wr_ptr <= nxt(wr_ptr);
      end else if (avm_m0_read) begin
        lock     <= 1'b1;
        lock_idx <= grant;
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      if (accept && !pop)      pending <= pending + PW'(1);
      else if (!accept && pop) pending <= pending - PW'(1);
      if (avm_m0_readdatavalid && pending == '0) orphan_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_avm_read_arbiter.sv
// Bench for avm_read_arbiter: a vector table for cycle-exact arbitration, then a
// memory model with a scoreboard queue checking routing of returned beats.
module tb_avm_read_arbiter;
  localparam int NREQ = 2, MAXPEND = 4, AW = 32;

  logic              clk = 1'b0, reset = 1'b1;
  logic [NREQ-1:0]   s_read = '0;
  logic [NREQ*AW-1:0] s_address = '0;
  logic [NREQ*2-1:0] s_byteenable = 4'b10_01;
  logic [NREQ-1:0]   s_waitrequest, s_readdatavalid;
  logic [15:0]       s_readdata, avm_m0_readdata = '0;
  logic              avm_m0_read, avm_m0_readdatavalid = 1'b0, avm_m0_waitrequest = 1'b0;
  logic [AW-1:0]     avm_m0_address;
  logic [1:0]        avm_m0_byteenable;
  logic [2:0]        pending;
  logic              orphan_err;

  avm_read_arbiter #(.NREQ(NREQ), .MAXPEND(MAXPEND), .AW(AW)) dut (
    .clk(clk), .reset(reset), .s_read(s_read), .s_address(s_address),
    .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .avm_m0_read(avm_m0_read),
    .avm_m0_address(avm_m0_address), .avm_m0_byteenable(avm_m0_byteenable),
    .avm_m0_readdata(avm_m0_readdata), .avm_m0_readdatavalid(avm_m0_readdatavalid),
    .avm_m0_waitrequest(avm_m0_waitrequest), .pending(pending), .orphan_err(orphan_err));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] rd; logic wt; logic rdv;
    logic ex_read; logic [31:0] ex_addr; logic [1:0] ex_be, ex_swait, ex_srdv; logic [2:0] ex_pend;
  } vec_t;
  vec_t vt [10];

  typedef struct { logic [1:0] onehot; logic [15:0] data; } exp_t;
  typedef struct { logic [15:0] data; int due; } mem_t;
  exp_t sb [$];
  mem_t memq [$];
  int   glog [$];

  int          rem [2];
  logic [31:0] base [2], offs [2];
  logic [1:0]  be [2];
  logic        stall, mem_en, force_rdv, last_read;
  logic [31:0] last_addr;
  logic [1:0]  last_swait;
  int          cyc = 0, acc_cnt, max_pend;
  localparam int LAT = 4;

  function automatic logic [15:0] data_of(input logic [31:0] a);
    return 16'h000a + (a[15:0] >> 1);
  endfunction

  // One cycle: drive at negedge, sample #1 later, then advance to the next negedge.
  task automatic step();
    exp_t e; mem_t m; logic [1:0] oh, sw; int o;
    for (int i = 0; i < 2; i++) begin
      s_read[i] = (rem[i] != 0);
      s_address[i*AW +: AW] = base[i] + offs[i];
    end
    avm_m0_waitrequest   = stall;
    avm_m0_readdatavalid = 1'b0;
    avm_m0_readdata      = 16'hdead;
    if (force_rdv) avm_m0_readdatavalid = 1'b1;
    else if (mem_en && memq.size() > 0 && memq[0].due <= cyc) begin
      m = memq.pop_front();
      avm_m0_readdatavalid = 1'b1;
      avm_m0_readdata = m.data;
    end
    #1;
    last_read = avm_m0_read; last_addr = avm_m0_address; last_swait = s_waitrequest;
    if (int'(pending) > max_pend) max_pend = int'(pending);
    if (avm_m0_read && !avm_m0_waitrequest) begin
      o  = int'(avm_m0_address[28]);
      oh = 2'b01 << o;
      sw = ~oh;
      chk("acc_swait", s_waitrequest, sw);
      chk("acc_addr", avm_m0_address, base[o] + offs[o]);
      chk("acc_be", avm_m0_byteenable, be[o]);
      e.onehot = oh; e.data = data_of(avm_m0_address);
      sb.push_back(e);
      m.data = e.data; m.due = cyc + LAT;
      memq.push_back(m);
      glog.push_back(o);
      acc_cnt++; rem[o]--; offs[o] += 2;
    end
    if (avm_m0_readdatavalid) begin
      if (sb.size() == 0) chk("orphan_no_rdv", s_readdatavalid, 2'b00);
      else begin
        e = sb.pop_front();
        chk("rdv_route", s_readdatavalid, e.onehot);
        chk("rdv_data", s_readdata, e.data);
      end
    end
    @(negedge clk); cyc++;
  endtask

  task automatic clear_model();
    sb.delete(); memq.delete(); glog.delete();
    rem[0] = 0; rem[1] = 0; offs[0] = 0; offs[1] = 0;
    acc_cnt = 0; max_pend = 0; stall = 0; mem_en = 1; force_rdv = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; s_read = '0; avm_m0_readdatavalid = 1'b0; avm_m0_waitrequest = 1'b0;
    clear_model();
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 80 && (rem[0] != 0 || rem[1] != 0 || sb.size() != 0); k++) step();
    chk({nm, "_drained"}, (rem[0] == 0 && rem[1] == 0 && sb.size() == 0), 1'b1);
  endtask

  initial begin
    int a0;
    base[0] = 32'h0000_0000; base[1] = 32'h1000_0100; be[0] = 2'b01; be[1] = 2'b10;
    clear_model();
    //       rd     wt   rdv  read  addr           be     swait  srdv   pend
    vt[0] = '{2'b00, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 2'b11, 2'b00, 3'd0};
    vt[1] = '{2'b11, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 2'b01, 2'b11, 2'b00, 3'd0};
    vt[2] = '{2'b11, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 2'b01, 2'b10, 2'b00, 3'd0};
    vt[3] = '{2'b11, 1'b0, 1'b0, 1'b1, 32'h1000_0020, 2'b10, 2'b01, 2'b00, 3'd1};
    vt[4] = '{2'b10, 1'b1, 1'b0, 1'b1, 32'h1000_0020, 2'b10, 2'b11, 2'b00, 3'd2};
    vt[5] = '{2'b11, 1'b1, 1'b0, 1'b1, 32'h1000_0020, 2'b10, 2'b11, 2'b00, 3'd2};
    vt[6] = '{2'b11, 1'b0, 1'b1, 1'b1, 32'h1000_0020, 2'b10, 2'b01, 2'b01, 3'd2};
    vt[7] = '{2'b00, 1'b0, 1'b1, 1'b0, 32'h0,         2'b00, 2'b11, 2'b10, 3'd2};
    vt[8] = '{2'b00, 1'b0, 1'b1, 1'b0, 32'h0,         2'b00, 2'b11, 2'b10, 3'd1};
    vt[9] = '{2'b00, 1'b0, 1'b1, 1'b0, 32'h0,         2'b00, 2'b11, 2'b00, 3'd0};

    // Reset state while reset is held, with a request pending on the inputs.
    s_read = 2'b11;
    #2;
    chk("rst_read", avm_m0_read, 1'b0);
    chk("rst_swait", s_waitrequest, 2'b11);
    chk("rst_srdv", s_readdatavalid, 2'b00);
    chk("rst_pend", pending, 3'd0);
    chk("rst_orphan", orphan_err, 1'b0);
    s_read = '0;
    @(negedge clk); @(negedge clk); reset = 1'b0;

    s_address = {32'h1000_0020, 32'h0000_0010};
    for (int i = 0; i < 10; i++) begin
      s_read = vt[i].rd; avm_m0_waitrequest = vt[i].wt; avm_m0_readdatavalid = vt[i].rdv;
      #1;
      chk($sformatf("v%0d_read", i), avm_m0_read, vt[i].ex_read);
      chk($sformatf("v%0d_addr", i), avm_m0_address, vt[i].ex_addr);
      chk($sformatf("v%0d_be", i), avm_m0_byteenable, vt[i].ex_be);
      chk($sformatf("v%0d_swait", i), s_waitrequest, vt[i].ex_swait);
      chk($sformatf("v%0d_srdv", i), s_readdatavalid, vt[i].ex_srdv);
      chk($sformatf("v%0d_pend", i), pending, vt[i].ex_pend);
      @(negedge clk);
    end
    avm_m0_readdatavalid = 1'b0;
    chk("v_orphan", orphan_err, 1'b1);

    // Single requester, two reads.
    do_reset();
    rem[0] = 2;
    drain("t1");
    chk("t1_acc", acc_cnt, 2);
    chk("t1_maxpend", max_pend, 2);
    chk("t1_pend_end", pending, 3'd0);

    // Both requesting: grants alternate 0,1,0,1.
    do_reset();
    rem[0] = 2; rem[1] = 2;
    drain("t2");
    chk("t2_nacc", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk($sformatf("t2_g%0d", i), glog[i], i % 2);

    // Requester 1 stalled for 3 cycles; requester 0 must wait behind the lock.
    do_reset();
    stall = 1; rem[1] = 1;
    step();
    chk("t3_addr0", last_addr, base[1]);
    chk("t3_swait0", last_swait, 2'b11);
    rem[0] = 1;
    for (int i = 1; i < 3; i++) begin
      step();
      chk($sformatf("t3_addr%0d", i), last_addr, base[1]);
      chk($sformatf("t3_read%0d", i), last_read, 1'b1);
    end
    stall = 0;
    step(); step();
    chk("t3_nacc", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("t3_first", glog[0], 1);
      chk("t3_second", glog[1], 0);
    end
    drain("t3");

    // Fill to MAXPEND with memory held off, then release one beat.
    do_reset();
    mem_en = 0; rem[0] = 6;
    for (int i = 0; i < 6; i++) step();
    chk("t4_acc_full", acc_cnt, 4);
    chk("t4_read_full", last_read, 1'b0);
    chk("t4_swait_full", last_swait, 2'b11);
    chk("t4_pend_full", pending, 3'd4);
    mem_en = 1;
    step();
    chk("t4_pop_cycle_acc", acc_cnt, 4);
    chk("t4_pop_cycle_read", last_read, 1'b0);
    step();
    chk("t4_next_acc", acc_cnt, 5);
    drain("t4");
    chk("t4_pend_end", pending, 3'd0);

    // Orphan beat: no routing pulse, sticky error.
    force_rdv = 1;
    step();
    force_rdv = 0;
    chk("t5_orphan", orphan_err, 1'b1);
    for (int i = 0; i < 3; i++) step();
    chk("t5_orphan_held", orphan_err, 1'b1);

    // Asynchronous reset with 3 reads outstanding.
    mem_en = 0; a0 = acc_cnt; rem[0] = 3;
    for (int k = 0; k < 10 && acc_cnt < a0 + 3; k++) step();
    chk("t6_pend3", pending, 3'd3);
    s_read = 2'b11;
    #1 reset = 1'b1;
    #1;
    chk("t6_pend_rst", pending, 3'd0);
    chk("t6_read_rst", avm_m0_read, 1'b0);
    chk("t6_swait_rst", s_waitrequest, 2'b11);
    chk("t6_orphan_rst", orphan_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    rem[0] = 1; rem[1] = 1;
    for (int k = 0; k < 10 && glog.size() == 0; k++) step();
    chk("t6_first_after_rst", (glog.size() > 0) ? glog[0] : -1, 0);
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
